// File: rtl/aes128_arb_ctrl_if.sv
// Bundle of the key, requester, AES core and result ports of aes128_arb_ctrl.
// The slave modport is the controller's view; master is the surrounding environment.
interface aes128_arb_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             key_we;
  logic [127:0]     key_in;
  logic             key_valid;
  logic             key_err;

  logic             req0_valid;
  logic             req0_ready;
  logic [127:0]     req0_data;
  logic             req0_inv;

  logic             req1_valid;
  logic             req1_ready;
  logic [127:0]     req1_data;
  logic             req1_inv;

  logic [127:0]     core_input;
  logic [127:0]     core_key;
  logic             core_inv;
  logic [127:0]     core_output;

  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             out_id;
  logic [CNT_W-1:0] blk_cnt;

  modport slave (
    input  key_we, key_in,
    output key_valid, key_err,
    input  req0_valid, req0_data, req0_inv,
    output req0_ready,
    input  req1_valid, req1_data, req1_inv,
    output req1_ready,
    output core_input, core_key, core_inv,
    input  core_output,
    output out_valid, out_data, out_id, blk_cnt,
    input  out_ready
  );

  modport master (
    output key_we, key_in,
    input  key_valid, key_err,
    output req0_valid, req0_data, req0_inv,
    input  req0_ready,
    output req1_valid, req1_data, req1_inv,
    input  req1_ready,
    input  core_input, core_key, core_inv,
    output core_output,
    input  out_valid, out_data, out_id, blk_cnt,
    output out_ready
  );
endinterface

// File: rtl/aes128_arb_ctrl.sv
// Shares one combinational AES128 core between two requesters: key holding,
// round-robin grant, fixed-latency wait and a tagged valid/ready result port.
//
// state | meaning
// IDLE  | no key loaded; requests are not accepted
// READY | key loaded; grant a requester or reload the key
// BUSY  | block registered into the core; counting down CORE_LAT
// DONE  | result captured; waiting for out_ready
module aes128_arb_ctrl #(
  parameter int CORE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  aes128_arb_ctrl_if.slave bus
);

  if (CORE_LAT < 1 || CORE_LAT > 15) begin : gLatRange
    $error("aes128_arb_ctrl: CORE_LAT must be within 1..15");
  end

  localparam logic [3:0] LAT_INIT = 4'(CORE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           stateNxt;

  logic [127:0]     keyReg;
  logic             keyValid;
  logic             keyErr;
  logic [127:0]     coreInput;
  logic             coreInv;
  logic [127:0]     outData;
  logic             outValid;
  logic             outId;
  logic [CNT_W-1:0] blkCnt;
  logic             lastGrant;
  logic [3:0]       latCnt;

  logic             grantVld;
  logic             grantId;
  logic             ready0;
  logic             ready1;
  logic             keyLoad;
  logic             keyReject;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    grantVld  = 1'b0;
    grantId   = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    keyLoad   = 1'b0;
    keyReject = 1'b0;
    case (state)
      IDLE: begin
        if (bus.key_we) begin
          keyLoad  = 1'b1;
          stateNxt = READY;
        end
      end
      READY: begin
        if (bus.key_we) begin
          keyLoad = 1'b1;
        end else begin
          // On a tie the requester that did not win last time gets the core.
          if (bus.req0_valid && bus.req1_valid) begin
            grantVld = 1'b1;
            grantId  = ~lastGrant;
          end else if (bus.req0_valid) begin
            grantVld = 1'b1;
            grantId  = 1'b0;
          end else if (bus.req1_valid) begin
            grantVld = 1'b1;
            grantId  = 1'b1;
          end
          ready0 = grantVld & ~grantId;
          ready1 = grantVld & grantId;
          if (grantVld) begin
            stateNxt = BUSY;
          end
        end
      end
      BUSY: begin
        keyReject = bus.key_we;
        if (latCnt == 4'd0) begin
          stateNxt = DONE;
        end
      end
      DONE: begin
        keyReject = bus.key_we;
        if (bus.out_ready) begin
          stateNxt = READY;
        end
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keyReg    <= '0;
      keyValid  <= 1'b0;
      keyErr    <= 1'b0;
      coreInput <= '0;
      coreInv   <= 1'b0;
      outData   <= '0;
      outValid  <= 1'b0;
      outId     <= 1'b0;
      blkCnt    <= '0;
      lastGrant <= 1'b1;
      latCnt    <= '0;
    end else begin
      keyErr <= keyReject;

      if (keyLoad) begin
        keyReg   <= bus.key_in;
        keyValid <= 1'b1;
      end

      if (grantVld) begin
        coreInput <= grantId ? bus.req1_data : bus.req0_data;
        coreInv   <= grantId ? bus.req1_inv : bus.req0_inv;
        outId     <= grantId;
        lastGrant <= grantId;
        latCnt    <= LAT_INIT;
      end

      if (state == BUSY) begin
        if (latCnt != 4'd0) begin
          latCnt <= latCnt - 4'd1;
        end else begin
          outData  <= bus.core_output;
          outValid <= 1'b1;
        end
      end

      if (state == DONE && bus.out_ready) begin
        outValid <= 1'b0;
        blkCnt   <= blkCnt + 1'b1;
      end
    end
  end

  assign bus.key_valid  = keyValid;
  assign bus.key_err    = keyErr;
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.core_input = coreInput;
  assign bus.core_key   = keyReg;
  assign bus.core_inv   = coreInv;
  assign bus.out_valid  = outValid;
  assign bus.out_data   = outData;
  assign bus.out_id     = outId;
  assign bus.blk_cnt    = blkCnt;

endmodule

// File: tb/tb_aes128_arb_ctrl.sv
// Bench for aes128_arb_ctrl: a stand-in AES core plus a transaction-level model of
// key, grant, latency and counter behaviour, driven by directed and random blocks.
module tb_aes128_arb_ctrl;

  localparam int LAT   = 2;
  // Narrow counter so the wrap from all-ones happens within a short run.
  localparam int CNT_W = 6;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [127:0]     mKey;
  bit               mLast;
  logic [CNT_W-1:0] mCnt;

  aes128_arb_ctrl_if #(.CNT_W(CNT_W)) bus ();

  aes128_arb_ctrl #(.CORE_LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in core: the FIPS-197 pair for the reference key, a keyed mix otherwise.
  function automatic logic [127:0] coreFn(input logic [127:0] din, input logic [127:0] key,
                                          input logic inv);
    if (key == FIPS_KEY && !inv && din == FIPS_PT) return FIPS_CT;
    if (key == FIPS_KEY && inv && din == FIPS_CT) return FIPS_PT;
    if (inv) return {din[63:0], din[127:64]} ^ ~key;
    return din ^ {key[119:0], key[127:120]};
  endfunction

  assign bus.core_output = coreFn(bus.core_input, bus.core_key, bus.core_inv);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic loadKey(input logic [127:0] k);
    bus.key_we     = 1'b1;
    bus.key_in     = k;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("kwe_ready0", bus.req0_ready, 0);
    chk("kwe_ready1", bus.req1_ready, 0);
    tick();
    bus.key_we     = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    mKey = k;
    chk("key_load", bus.core_key, mKey);
    chk("key_valid", bus.key_valid, 1);
    chk("key_err_load", bus.key_err, 0);
  endtask

  task automatic runBlock(input bit v0, input logic [127:0] d0, input bit i0,
                          input bit v1, input logic [127:0] d1, input bit i1,
                          input int hold, input bit kwe);
    bit               g;
    bit               iin;
    logic [127:0]     din;
    logic [127:0]     exp;
    logic [CNT_W-1:0] nextCnt;
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req0_inv   = i0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    bus.req1_inv   = i1;
    #1;
    g   = (v0 && v1) ? !mLast : v1;
    din = g ? d1 : d0;
    iin = g ? i1 : i0;
    exp = coreFn(din, mKey, iin);
    chk("grant_ready0", bus.req0_ready, !g);
    chk("grant_ready1", bus.req1_ready, g);
    tick();
    mLast = g;
    chk("core_input", bus.core_input, din);
    chk("core_inv", bus.core_inv, iin);
    for (int k = 0; k < LAT; k++) begin
      if (kwe && k == 0) begin
        bus.key_we = 1'b1;
        bus.key_in = ~mKey;
      end
      chk("busy_out_valid", bus.out_valid, 0);
      chk("busy_ready", {bus.req0_ready, bus.req1_ready}, 0);
      chk("busy_input_hold", bus.core_input, din);
      tick();
      if (kwe && k == 0) begin
        bus.key_we = 1'b0;
        chk("key_err_pulse", bus.key_err, 1);
        chk("key_kept", bus.core_key, mKey);
      end else begin
        chk("key_err_quiet", bus.key_err, 0);
      end
    end
    chk("out_valid_rise", bus.out_valid, 1);
    chk("out_data", bus.out_data, exp);
    chk("out_id", bus.out_id, g);
    for (int h = 0; h < hold; h++) begin
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req1_valid = 1'($urandom_range(0, 1));
      #1;
      chk("done_ready", {bus.req0_ready, bus.req1_ready}, 0);
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, exp);
      chk("hold_id", bus.out_id, g);
      chk("hold_key_err", bus.key_err, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("handshake_ready", {bus.req0_ready, bus.req1_ready}, 0);
    tick();
    bus.out_ready = 1'b0;
    nextCnt = mCnt + 1'b1;
    chk("out_valid_fall", bus.out_valid, 0);
    chk((mCnt == '1) ? "blk_wrap" : "blk_cnt", bus.blk_cnt, nextCnt);
    mCnt = nextCnt;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] ra;
    logic [127:0] rb;
    int           sel;
    vectors     = 0;
    miscompares = 0;
    mKey  = '0;
    mLast = 1'b1;
    mCnt  = '0;
    rst_n          = 1'b0;
    bus.key_we     = 1'b0;
    bus.key_in     = '0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req0_inv   = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.req1_inv   = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_key_valid", bus.key_valid, 0);
    chk("rst_core_key", bus.core_key, 0);
    chk("rst_core_input", bus.core_input, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_blk_cnt", bus.blk_cnt, 0);
    bus.req0_valid = 1'b1;
    #1;
    chk("idle_ready0", bus.req0_ready, 0);
    tick();
    chk("idle_no_accept", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;

    loadKey(FIPS_KEY);
    runBlock(1'b1, FIPS_PT, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
    runBlock(1'b0, '0, 1'b0, 1'b1, FIPS_CT, 1'b1, 0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      runBlock(1'b1, FIPS_PT, 1'b0, 1'b1, FIPS_CT, 1'b1, 0, 1'b0);
    end
    runBlock(1'b1, FIPS_PT, 1'b0, 1'b0, '0, 1'b0, 5, 1'b0);
    runBlock(1'b0, '0, 1'b0, 1'b1, FIPS_PT, 1'b0, 1, 1'b1);
    runBlock(1'b1, '0, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);

    loadKey({$urandom, $urandom, $urandom, $urandom});
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) loadKey({$urandom, $urandom, $urandom, $urandom});
      sel = int'($urandom_range(1, 3));
      ra  = (n % 16 == 5) ? '0 : {$urandom, $urandom, $urandom, $urandom};
      rb  = {$urandom, $urandom, $urandom, $urandom};
      runBlock(1'(sel & 1), ra, 1'($urandom_range(0, 1)),
               1'((sel >> 1) & 1), rb, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
    end

    bus.req0_valid = 1'b1;
    bus.req0_data  = FIPS_PT;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mKey  = '0;
    mLast = 1'b1;
    mCnt  = '0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_key_valid", bus.key_valid, 0);
    chk("midrst_core_key", bus.core_key, 0);
    chk("midrst_core_input", bus.core_input, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_blk_cnt", bus.blk_cnt, 0);
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      chk("postrst_out_valid", bus.out_valid, 0);
    end
    loadKey(FIPS_KEY);
    runBlock(1'b1, FIPS_PT, 1'b0, 1'b1, FIPS_CT, 1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
